// File: rtl/lynxTypes.sv
// rtl/lynxTypes.sv - shared types for the TCP TX route tagging path
package lynxTypes;

  localparam int POS_ROUTE_ID_BITS = 14;

  typedef logic [13:0] route_id_t;

  typedef enum logic {
    TAG_HEAD = 1'b0,
    TAG_BODY = 1'b1
  } tag_state_t;

endpackage

// File: rtl/tcp_route_id_fifo.sv
// rtl/tcp_route_id_fifo.sv - synchronous route_id FIFO with occupancy and drop flag
module tcp_route_id_fifo
  import lynxTypes::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  route_id_t                push_data,
  input  logic                     pop,
  output route_id_t                pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  route_id_t       mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            do_push;
  logic            do_pop;

  // Occupancy is the pointer difference; the extra pointer bit separates full from empty.
  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && full && !do_pop;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer update on accepted push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/tcp_tx_route_tagger.sv
// rtl/tcp_tx_route_tagger.sv - binds queued route_ids to outgoing TX AXIS packets
module tcp_tx_route_tagger
  import lynxTypes::*;
#(
  parameter int        DATA_BITS     = 512,
  parameter int        ROUTE_DEPTH   = 16,
  parameter int        TIMEOUT_CYC   = 1024,
  parameter route_id_t DEFAULT_ROUTE = 14'h0
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  route_id_t                      s_route_id,
  input  logic                           s_route_id_valid,
  input  logic [DATA_BITS-1:0]           s_axis_tdata,
  input  logic [DATA_BITS/8-1:0]         s_axis_tkeep,
  input  logic                           s_axis_tlast,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  output logic [DATA_BITS-1:0]           m_axis_tdata,
  output logic [DATA_BITS/8-1:0]         m_axis_tkeep,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output route_id_t                      m_axis_route_id,
  output logic                           err_overflow,
  output logic                           err_timeout,
  output logic [$clog2(ROUTE_DEPTH):0]   route_count
);

  localparam int              WW         = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WW-1:0]   WAIT_LIMIT = WW'(TIMEOUT_CYC - 1);

  tag_state_t       state;
  route_id_t        cur_route;
  logic [WW-1:0]    wait_cnt;

  route_id_t        fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_overflow;

  logic             out_free;
  logic             timeout_hit;
  logic             accept;
  logic             head_accept;
  logic             fifo_pop;
  route_id_t        head_route;

  assign out_free    = !m_axis_tvalid || m_axis_tready;
  assign timeout_hit = (wait_cnt >= WAIT_LIMIT);
  // A head beat needs a route_id, unless it has waited long enough to take the fallback.
  assign s_axis_tready = (state == TAG_HEAD) ? (out_free && (!fifo_empty || timeout_hit))
                                             : out_free;
  assign accept      = s_axis_tvalid && s_axis_tready;
  assign head_accept = accept && (state == TAG_HEAD);
  assign fifo_pop    = head_accept && !fifo_empty;
  assign head_route  = fifo_empty ? DEFAULT_ROUTE : fifo_head;

  tcp_route_id_fifo #(
    .DEPTH (ROUTE_DEPTH)
  ) u_route_fifo (
    .clk       (aclk),
    .rst       (areset),
    .push      (s_route_id_valid),
    .push_data (s_route_id),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (route_count),
    .overflow  (fifo_overflow)
  );

  // Packet framing FSM, head wait counter, held route and sticky error flags.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state        <= TAG_HEAD;
      cur_route    <= '0;
      wait_cnt     <= '0;
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      if (fifo_overflow) err_overflow <= 1'b1;

      if (accept) begin
        wait_cnt <= '0;
      end else if ((state == TAG_HEAD) && s_axis_tvalid && fifo_empty && !(&wait_cnt)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      case (state)
        TAG_HEAD: begin
          if (head_accept) begin
            cur_route <= head_route;
            if (fifo_empty)     err_timeout <= 1'b1;
            if (!s_axis_tlast)  state <= TAG_BODY;
          end
        end
        TAG_BODY: begin
          if (accept && s_axis_tlast) state <= TAG_HEAD;
        end
        default: state <= TAG_HEAD;
      endcase
    end
  end

  // Single output register slice; holds everything while the VIU stalls.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_axis_tvalid   <= 1'b0;
      m_axis_tdata    <= '0;
      m_axis_tkeep    <= '0;
      m_axis_tlast    <= 1'b0;
      m_axis_route_id <= '0;
    end else if (accept) begin
      m_axis_tvalid   <= 1'b1;
      m_axis_tdata    <= s_axis_tdata;
      m_axis_tkeep    <= s_axis_tkeep;
      m_axis_tlast    <= s_axis_tlast;
      m_axis_route_id <= head_accept ? head_route : cur_route;
    end else if (m_axis_tready) begin
      m_axis_tvalid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tcp_tx_route_tagger.sv
// tb/tb_tcp_tx_route_tagger.sv - directed self-checking bench for tcp_tx_route_tagger
module tb_tcp_tx_route_tagger;
  import lynxTypes::*;

  localparam int        DB  = 64;
  localparam int        KB  = DB / 8;
  localparam int        RD  = 16;
  localparam int        TO  = 1024;
  localparam route_id_t DEF = 14'h2A5;

  logic               aclk = 1'b0;
  logic               areset = 1'b1;
  route_id_t          s_route_id = '0;
  logic               s_route_id_valid = 1'b0;
  logic [DB-1:0]      s_tdata = '0;
  logic [KB-1:0]      s_tkeep = '0;
  logic               s_tlast = 1'b0;
  logic               s_tvalid = 1'b0;
  logic               s_tready;
  logic [DB-1:0]      m_tdata;
  logic [KB-1:0]      m_tkeep;
  logic               m_tlast;
  logic               m_tvalid;
  logic               m_tready = 1'b1;
  route_id_t          m_route_id;
  logic               err_overflow;
  logic               err_timeout;
  logic [$clog2(RD):0] route_count;

  tcp_tx_route_tagger #(
    .DATA_BITS     (DB),
    .ROUTE_DEPTH   (RD),
    .TIMEOUT_CYC   (TO),
    .DEFAULT_ROUTE (DEF)
  ) dut (
    .aclk             (aclk),
    .areset           (areset),
    .s_route_id       (s_route_id),
    .s_route_id_valid (s_route_id_valid),
    .s_axis_tdata     (s_tdata),
    .s_axis_tkeep     (s_tkeep),
    .s_axis_tlast     (s_tlast),
    .s_axis_tvalid    (s_tvalid),
    .s_axis_tready    (s_tready),
    .m_axis_tdata     (m_tdata),
    .m_axis_tkeep     (m_tkeep),
    .m_axis_tlast     (m_tlast),
    .m_axis_tvalid    (m_tvalid),
    .m_axis_tready    (m_tready),
    .m_axis_route_id  (m_route_id),
    .err_overflow     (err_overflow),
    .err_timeout      (err_timeout),
    .route_count      (route_count)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [DB-1:0] data;
    logic          last;
    route_id_t     route;
    int            cyc;
  } beat_t;

  beat_t outq[$];
  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;
  int    stalls = 0;

  always @(posedge aclk) cyc = cyc + 1;

  // Output capture: a beat transfers when valid and ready are both high mid-cycle.
  always @(negedge aclk) begin
    if (m_tvalid && m_tready && !areset)
      outq.push_back('{m_tdata, m_tlast, m_route_id, cyc});
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    step();
    step();
    areset = 1'b0;
    step();
  endtask

  task automatic push_route(input route_id_t id);
    s_route_id       = id;
    s_route_id_valid = 1'b1;
    step();
    s_route_id_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [DB-1:0] d, input logic last);
    bit done;
    int n;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = '1;
    s_tlast  = last;
    done = 0;
    n = 0;
    while (!done) begin
      #1;
      if (s_tready) done = 1;
      else stalls = stalls + 1;
      @(posedge aclk);
      #1;
      n = n + 1;
      if (!done && n > 4000) begin
        errors = errors + 1;
        checks = checks + 1;
        $display("FAIL beat_accept_timeout: data %h never accepted", d);
        done = 1;
      end
    end
    checks = checks + 1;
    if (m_tvalid !== 1'b1 || m_tdata !== d) begin
      errors = errors + 1;
      $display("FAIL out_latency: got valid=%b data=%h expected valid=1 data=%h", m_tvalid, m_tdata, d);
    end
  endtask

  task automatic send_pkt(input logic [DB-1:0] base, input int nbeats);
    for (int i = 0; i < nbeats; i++) send_beat(base + DB'(i), (i == nbeats - 1));
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    areset = 1'b1;
    #1;
    checks = checks + 6;
    if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b expected 0", m_tvalid); end
    if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b expected 0", s_tready); end
    if (route_count !== '0) begin errors++; $display("FAIL rst_count: got %0d expected 0", route_count); end
    if (err_overflow !== 1'b0 || err_timeout !== 1'b0) begin
      errors++; $display("FAIL rst_err: got ovf=%b to=%b expected 0 0", err_overflow, err_timeout);
    end
    if (m_tdata !== '0 || m_tkeep !== '0 || m_tlast !== 1'b0) begin
      errors++; $display("FAIL rst_data: got %h expected 0", m_tdata);
    end
    if (m_route_id !== '0) begin errors++; $display("FAIL rst_route: got %h expected 0", m_route_id); end
    areset = 1'b0;
    step();
  endtask

  task automatic test_single_packet();
    push_route(14'h123);
    checks++;
    if (route_count !== 1) begin errors++; $display("FAIL single_count_pre: got %0d expected 1", route_count); end
    outq.delete();
    send_pkt(64'hA0, 4);
    step();
    checks++;
    if (route_count !== 0) begin errors++; $display("FAIL single_count_post: got %0d expected 0", route_count); end
    checks++;
    if (outq.size() != 4) begin
      errors++; $display("FAIL single_beats: got %0d expected 4", outq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (outq[i].data !== 64'hA0 + 64'(i) || outq[i].route !== 14'h123 ||
            outq[i].last !== (i == 3) || outq[i].cyc != outq[0].cyc + i) begin
          errors++;
          $display("FAIL single_beat%0d: got data=%h route=%h last=%b expected data=%h route=123 last=%b",
                   i, outq[i].data, outq[i].route, outq[i].last, 64'hA0 + 64'(i), (i == 3));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    route_id_t exp_r [6] = '{14'h001, 14'h001, 14'h002, 14'h002, 14'h003, 14'h003};
    push_route(14'h001);
    push_route(14'h002);
    push_route(14'h003);
    outq.delete();
    stalls = 0;
    send_pkt(64'h10, 2);
    send_pkt(64'h20, 2);
    send_pkt(64'h30, 2);
    step();
    checks++;
    if (stalls != 0) begin errors++; $display("FAIL b2b_stalls: got %0d expected 0", stalls); end
    checks++;
    if (outq.size() != 6) begin
      errors++; $display("FAIL b2b_beats: got %0d expected 6", outq.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (outq[i].route !== exp_r[i] || outq[i].cyc != outq[0].cyc + i) begin
          errors++;
          $display("FAIL b2b_beat%0d: got route=%h cyc=%0d expected route=%h cyc=%0d",
                   i, outq[i].route, outq[i].cyc, exp_r[i], outq[0].cyc + i);
        end
      end
    end
    checks++;
    if (err_overflow !== 1'b0 || err_timeout !== 1'b0) begin
      errors++; $display("FAIL b2b_err: got ovf=%b to=%b expected 0 0", err_overflow, err_timeout);
    end
  endtask

  task automatic test_stall();
    push_route(14'h055);
    outq.delete();
    m_tready = 1'b0;
    fork
      send_pkt(64'h50, 4);
      begin
        for (int i = 0; i < 12; i++) begin
          step();
          m_tready = ~m_tready;
        end
        m_tready = 1'b1;
      end
      begin
        logic          held;
        logic [DB-1:0] hd;
        route_id_t     hr;
        held = 1'b0;
        hd = '0;
        hr = '0;
        for (int i = 0; i < 16; i++) begin
          @(negedge aclk);
          if (held) begin
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== hd || m_route_id !== hr) begin
              errors++;
              $display("FAIL stall_hold: got valid=%b data=%h route=%h expected 1 %h %h",
                       m_tvalid, m_tdata, m_route_id, hd, hr);
            end
          end
          held = m_tvalid && !m_tready;
          hd   = m_tdata;
          hr   = m_route_id;
        end
      end
    join
    m_tready = 1'b1;
    step();
    step();
    checks++;
    if (outq.size() != 4) begin
      errors++; $display("FAIL stall_beats: got %0d expected 4", outq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (outq[i].data !== 64'h50 + 64'(i) || outq[i].route !== 14'h055) begin
          errors++;
          $display("FAIL stall_beat%0d: got data=%h route=%h expected data=%h route=055",
                   i, outq[i].data, outq[i].route, 64'h50 + 64'(i));
        end
      end
    end
  endtask

  task automatic test_overflow();
    checks++;
    if (err_overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre: got %b expected 0", err_overflow); end
    for (int i = 0; i <= RD; i++) push_route(14'h200 + 14'(i));
    checks++;
    if (route_count !== RD) begin errors++; $display("FAIL ovf_count: got %0d expected %0d", route_count, RD); end
    checks++;
    if (err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", err_overflow); end
    outq.delete();
    for (int i = 0; i < RD; i++) send_pkt(64'h300 + 64'(i), 1);
    step();
    checks++;
    if (outq.size() != RD) begin
      errors++; $display("FAIL ovf_drain_beats: got %0d expected %0d", outq.size(), RD);
    end else begin
      for (int i = 0; i < RD; i++) begin
        checks++;
        if (outq[i].route !== 14'h200 + 14'(i)) begin
          errors++; $display("FAIL ovf_drain%0d: got %h expected %h", i, outq[i].route, 14'h200 + 14'(i));
        end
      end
    end
    checks++;
    if (route_count !== 0 || err_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_post: got count=%0d ovf=%b expected 0 1", route_count, err_overflow);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    checks++;
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_pre: got %b expected 0", err_timeout); end
    outq.delete();
    stalls = 0;
    send_pkt(64'hE0, 1);
    step();
    checks++;
    if (stalls != TO - 1) begin errors++; $display("FAIL to_wait: got %0d expected %0d", stalls, TO - 1); end
    checks++;
    if (outq.size() != 1 || outq[0].route !== DEF) begin
      errors++; $display("FAIL to_route: got n=%0d expected 1 beat with route %h", outq.size(), DEF);
    end
    checks++;
    if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_flag: got %b expected 1", err_timeout); end
    push_route(14'h3AB);
    outq.delete();
    stalls = 0;
    send_pkt(64'hE1, 1);
    step();
    checks++;
    if (stalls != 0 || outq.size() != 1 || outq[0].route !== 14'h3AB) begin
      errors++; $display("FAIL to_next: got stalls=%0d n=%0d expected 0 stalls, one beat route 3ab",
                         stalls, outq.size());
    end
  endtask

  task automatic test_reset_mid_packet();
    push_route(14'h0C1);
    send_beat(64'hC0, 1'b0);
    send_beat(64'hC1, 1'b0);
    areset   = 1'b1;
    s_tvalid = 1'b0;
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || m_tdata !== '0 || m_route_id !== '0 || m_tlast !== 1'b0) begin
      errors++; $display("FAIL mid_rst_out: got valid=%b data=%h route=%h expected 0 0 0",
                         m_tvalid, m_tdata, m_route_id);
    end
    checks++;
    if (route_count !== '0 || s_tready !== 1'b0 || err_timeout !== 1'b0) begin
      errors++; $display("FAIL mid_rst_state: got count=%0d ready=%b to=%b expected 0 0 0",
                         route_count, s_tready, err_timeout);
    end
    step();
    areset = 1'b0;
    step();
    push_route(14'h0D2);
    outq.delete();
    send_pkt(64'hF0, 2);
    step();
    checks++;
    if (outq.size() != 2) begin
      errors++; $display("FAIL mid_rst_beats: got %0d expected 2", outq.size());
    end else begin
      checks++;
      if (outq[0].route !== 14'h0D2 || outq[1].route !== 14'h0D2 ||
          outq[0].data !== 64'hF0 || outq[1].data !== 64'hF1) begin
        errors++; $display("FAIL mid_rst_route: got %h/%h expected 0d2/0d2", outq[0].route, outq[1].route);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_timeout();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
